// File: rtl/code_scan_if.sv
// Pushbutton/switch inputs and decoder-select outputs of code_scan.
// The board side drives the keys; code_scan drives the code and status.
interface code_scan_if;
    logic key_mode;
    logic key_step;
    logic dir;
    logic out1;
    logic out2;
    logic out3;
    logic auto_mode;
    logic step_pulse;

    modport master (
        output key_mode, key_step, dir,
        input  out1, out2, out3, auto_mode, step_pulse
    );

    modport slave (
        input  key_mode, key_step, dir,
        output out1, out2, out3, auto_mode, step_pulse
    );
endinterface

// File: rtl/code_scan.sv
// Select-code generator for a 3-to-8 decoder: steps 000..110 either on a
// prescaled auto tick or on debounced key presses; 111 is never produced.
module code_scan #(
    parameter int CNT_MAX = 24_999_999,
    parameter int DEB_MAX = 999_999
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    code_scan_if.slave   bus
);
    localparam int PW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int DW = (DEB_MAX > 0) ? $clog2(DEB_MAX + 1) : 1;
    localparam logic [PW-1:0] PRESC_TOP = PW'(CNT_MAX);
    localparam logic [DW-1:0] DEB_TOP   = DW'(DEB_MAX);
    localparam logic [DW-1:0] DEB_ARM   = DW'(DEB_MAX - 1);

    typedef enum logic {ST_AUTO, ST_MANUAL} state_t;

    state_t                 r_state;
    logic [PW-1:0]          r_presc;
    logic [2:0]             r_code;
    logic                   r_auto;
    logic                   r_pulse;
    logic [2:0]             r_sync1;
    logic [2:0]             r_sync2;
    logic [1:0][DW-1:0]     r_deb_cnt;

    logic [1:0]             w_key_s;
    logic [1:0]             w_press;
    logic                   w_mode_press;
    logic                   w_step_press;
    logic                   w_dir;

    // Sync bit order: 0 = key_mode, 1 = key_step, 2 = dir; keys idle high.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync1 <= 3'b011;
            r_sync2 <= 3'b011;
        end else begin
            r_sync1 <= {bus.dir, bus.key_step, bus.key_mode};
            r_sync2 <= r_sync1;
        end
    end

    assign w_key_s = r_sync2[1:0];
    assign w_dir   = r_sync2[2];

    // The low-level gate keeps a bounce that releases exactly at DEB_MAX-1 silent.
    always_comb begin
        w_press = '0;
        for (int k = 0; k < 2; k++) begin
            w_press[k] = !w_key_s[k] && (r_deb_cnt[k] == DEB_ARM);
        end
    end

    assign w_mode_press = w_press[0];
    assign w_step_press = w_press[1];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_deb_cnt <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (w_key_s[k]) begin
                    r_deb_cnt[k] <= '0;
                end else if (r_deb_cnt[k] != DEB_TOP) begin
                    r_deb_cnt[k] <= r_deb_cnt[k] + DW'(1);
                end
            end
        end
    end

    function automatic logic [2:0] next_code(input logic [2:0] code, input logic up);
        if (code == 3'b111) begin
            return 3'b000;
        end
        if (up) begin
            return (code == 3'b110) ? 3'b000 : code + 3'd1;
        end
        return (code == 3'b000) ? 3'b110 : code - 3'd1;
    endfunction

    // A mode press always wins over a step in the same cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_AUTO;
            r_presc <= '0;
            r_code  <= 3'b000;
            r_auto  <= 1'b1;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (w_mode_press) begin
                r_presc <= '0;
                if (r_state == ST_AUTO) begin
                    r_state <= ST_MANUAL;
                    r_auto  <= 1'b0;
                end else begin
                    r_state <= ST_AUTO;
                    r_auto  <= 1'b1;
                end
            end else if (r_state == ST_AUTO) begin
                if (r_presc == PRESC_TOP) begin
                    r_presc <= '0;
                    r_code  <= next_code(r_code, w_dir);
                    r_pulse <= 1'b1;
                end else begin
                    r_presc <= r_presc + PW'(1);
                end
            end else begin
                r_presc <= '0;
                if (w_step_press) begin
                    r_code  <= next_code(r_code, w_dir);
                    r_pulse <= 1'b1;
                end
            end
        end
    end

    assign bus.out1       = r_code[2];
    assign bus.out2       = r_code[1];
    assign bus.out3       = r_code[0];
    assign bus.auto_mode  = r_auto;
    assign bus.step_pulse = r_pulse;
endmodule

// File: tb/tb_code_scan.sv
// Randomized and directed bench for code_scan against a cycle-level
// behavioural model using modulo-7 code arithmetic.
module tb_code_scan;
    localparam int CNT_MAX = 9;
    localparam int DEB_MAX = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    code_scan_if bus ();

    code_scan #(.CNT_MAX(CNT_MAX), .DEB_MAX(DEB_MAX)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int obs_pulses = 0;

    // Reference model state
    int m_code;
    bit m_auto;
    bit m_pulse;
    int m_elapsed;
    bit [1:0] m_s1, m_s2;
    int m_run[2];
    bit m_dir1, m_dir2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int step_of(input int c, input bit up);
        return up ? (c + 1) % 7 : (c + 6) % 7;
    endfunction

    task automatic m_reset();
        m_code = 0; m_auto = 1'b1; m_pulse = 1'b0; m_elapsed = 0;
        m_s1 = 2'b11; m_s2 = 2'b11; m_run[0] = 0; m_run[1] = 0;
        m_dir1 = 1'b0; m_dir2 = 1'b0;
    endtask

    // One clock edge: a key counts as pressed on the DEB_MAX-th consecutive synced-low cycle.
    task automatic m_edge();
        bit mp, sp;
        mp = !m_s2[0] && (m_run[0] == DEB_MAX);
        sp = !m_s2[1] && (m_run[1] == DEB_MAX);
        m_pulse = 1'b0;
        if (mp) begin
            m_auto = !m_auto;
            m_elapsed = 0;
        end else if (m_auto) begin
            if (m_elapsed == CNT_MAX) begin
                m_code = step_of(m_code, m_dir2);
                m_pulse = 1'b1;
                m_elapsed = 0;
            end else begin
                m_elapsed++;
            end
        end else if (sp) begin
            m_code = step_of(m_code, m_dir2);
            m_pulse = 1'b1;
        end
        m_s2 = m_s1;
        m_s1 = {bus.key_step, bus.key_mode};
        m_dir2 = m_dir1;
        m_dir1 = bus.dir;
        for (int k = 0; k < 2; k++) begin
            if (m_s2[k]) m_run[k] = 0;
            else if (m_run[k] <= DEB_MAX) m_run[k] = m_run[k] + 1;
        end
    endtask

    task automatic compare(input string tag);
        logic [2:0] c;
        c = {bus.out1, bus.out2, bus.out3};
        chk({tag, "_code"}, c, m_code);
        chk({tag, "_auto"}, bus.auto_mode, m_auto);
        chk({tag, "_pulse"}, bus.step_pulse, m_pulse);
        chk({tag, "_no111"}, (c == 3'b111), 0);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            m_edge();
            compare("cyc");
            if (bus.step_pulse) obs_pulses++;
        end
    endtask

    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        compare(tag);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic key_press(input bit is_mode, input int lo, input int hi);
        if (is_mode) bus.key_mode = 1'b0; else bus.key_step = 1'b0;
        cyc(lo);
        if (is_mode) bus.key_mode = 1'b1; else bus.key_step = 1'b1;
        cyc(hi);
    endtask

    initial begin
        int c0, p0, first, hold_m, hold_s;
        bit found;
        bus.key_mode = 1'b1;
        bus.key_step = 1'b1;
        bus.dir      = 1'b1;

        // Power-on reset, count up
        #1 rst_n = 1'b0;
        #1;
        m_reset();
        compare("por");
        #1 rst_n = 1'b1;
        p0 = obs_pulses;
        cyc(70);
        chk("up_pulses", obs_pulses - p0, 7);
        chk("up_wrap_code", {bus.out1, bus.out2, bus.out3}, 0);

        // Count down from reset, then reverse mid-run
        bus.dir = 1'b0;
        do_reset("rst_dn");
        cyc(10);
        chk("dn_first", {bus.out1, bus.out2, bus.out3}, 6);
        cyc(10);
        chk("dn_second", {bus.out1, bus.out2, bus.out3}, 5);
        bus.dir = 1'b1;
        cyc(10);
        chk("dir_flip_up", {bus.out1, bus.out2, bus.out3}, 6);

        // Long mode hold: one toggle into MANUAL, then three step presses
        key_press(1'b1, 20, 5);
        chk("manual_mode", bus.auto_mode, 0);
        c0 = m_code;
        p0 = obs_pulses;
        repeat (3) key_press(1'b0, 8, 8);
        chk("manual_steps", obs_pulses - p0, 3);
        chk("manual_code", {bus.out1, bus.out2, bus.out3}, (c0 + 3) % 7);

        // Bouncy step key: short lows are filtered, the stable low steps once
        p0 = obs_pulses;
        key_press(1'b0, 2, 1);
        key_press(1'b0, 3, 1);
        key_press(1'b0, 10, 5);
        chk("bounce_steps", obs_pulses - p0, 1);

        // Back to AUTO; step presses there are ignored by the model too
        key_press(1'b1, 6, 4);
        chk("back_auto", bus.auto_mode, 1);
        repeat (3) key_press(1'b0, 6, 6);

        // Mode press landing exactly on the auto tick
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_auto && m_elapsed == CNT_MAX - DEB_MAX - 1) found = 1'b1;
            else cyc(1);
        end
        chk("collide_found", found, 1);
        c0 = m_code;
        bus.key_mode = 1'b0;
        cyc(DEB_MAX + 2);
        chk("collide_auto", bus.auto_mode, 0);
        chk("collide_code", {bus.out1, bus.out2, bus.out3}, c0);
        chk("collide_pulse", bus.step_pulse, 0);
        bus.key_mode = 1'b1;
        cyc(6);

        // Reach code 101 in MANUAL, then reset asynchronously
        bus.dir = 1'b1;
        cyc(4);
        for (int i = 0; i < 10 && m_code != 5; i++) key_press(1'b0, 6, 4);
        chk("pre_rst_code", {bus.out1, bus.out2, bus.out3}, 5);
        chk("pre_rst_manual", bus.auto_mode, 0);
        do_reset("rst_mid");
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            if (bus.step_pulse && first == 0) first = k;
        end
        chk("rst_first_step", first, CNT_MAX + 1);

        // Randomized key and switch activity
        hold_m = 30;
        hold_s = 5;
        for (int i = 0; i < 3000; i++) begin
            if (hold_m == 0) begin
                bus.key_mode = ~bus.key_mode;
                hold_m = bus.key_mode ? $urandom_range(1, 40) : $urandom_range(1, 8);
            end
            hold_m--;
            if (hold_s == 0) begin
                bus.key_step = ~bus.key_step;
                hold_s = $urandom_range(1, 10);
            end
            hold_s--;
            if ($urandom_range(0, 49) == 0) bus.dir = ~bus.dir;
            if (i == 1500) do_reset("rst_rnd");
            cyc(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/code_scan.md
# code_scan

Sequential select-code generator that drives the 3-bit input of the downstream 3-to-8 one-hot decoder. In auto mode it steps the code at a prescaled rate; in manual mode each debounced press of a step key advances it by one. The code sequence covers 3'b000..3'b110 only and never emits 3'b111, which the decoder does not decode. Sits between the board pushbuttons/switch and the decoder's in1/in2/in3 inputs.

## Interface
- CNT_MAX, 24_999_999 — auto-step prescaler terminal count; one step every CNT_MAX+1 clocks (0.5 s at 50 MHz).
- DEB_MAX, 999_999 — debounce terminal count; key must be stably low DEB_MAX clocks (20 ms at 50 MHz).
- sys_clk  in  1  system clock, all logic on rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- key_mode  in  1  raw pushbutton, active-low; each press toggles AUTO/MANUAL.
- key_step  in  1  raw pushbutton, active-low; each press steps the code in MANUAL.
- dir  in  1  raw switch; 1 = count up, 0 = count down.
- out1  out  1  code bit 2 (MSB), to decoder in1.
- out2  out  1  code bit 1, to decoder in2.
- out3  out  1  code bit 0 (LSB), to decoder in3.
- auto_mode  out  1  1 = AUTO state, 0 = MANUAL.
- step_pulse  out  1  one-cycle pulse, high in the cycle the code changes.

## Operation
- Inputs key_mode, key_step, dir each pass a 2-flop synchronizer before use.
- Debouncer per key: counter (width ceil(log2(DEB_MAX+1))) increments while synced key is 0, saturates at DEB_MAX; synced key 1 clears it to 0. Press pulse high for exactly the one cycle the counter holds DEB_MAX-1. One pulse per press regardless of hold length; bounces shorter than DEB_MAX clocks produce no pulse.
- State machine, two states: AUTO (reset state), MANUAL. mode press toggles state. Prescaler cleared to 0 on every state change.
- AUTO: prescaler counts 0..CNT_MAX, wraps to 0; tick when prescaler == CNT_MAX. Tick steps the code. step presses ignored.
- MANUAL: prescaler held at 0; step press steps the code.
- Step: code = {out1,out2,out3}. dir=1: code+1, 3'b110 wraps to 3'b000. dir=0: code-1, 3'b000 wraps to 3'b110. Code 3'b111 is unreachable; if ever present (fault), next step forces 3'b000.
- Simultaneous: mode press and auto tick in same cycle — state toggles, no step. mode press and step press in same cycle in MANUAL — state toggles to AUTO, no step.
- dir is sampled at the step cycle; changing dir between steps changes direction on the next step only.

## Timing
- Reset values: out1/out2/out3 = 0 (code 3'b000), auto_mode = 1, step_pulse = 0, prescaler, debounce counters and synchronizers 0 / idle (synced keys reset to 1).
- Reset asserted mid-operation: all of the above within the same clock-independent assertion; first step after release requires a full prescaler period (CNT_MAX+1 clocks) in AUTO.
- AUTO: code registers update on the edge after the cycle prescaler == CNT_MAX; step_pulse high that same updated cycle.
- Key latency: raw key low at edge N -> synced low at N+2 -> press pulse at N+2+DEB_MAX-1 -> code / auto_mode registered on the following edge; step_pulse coincident with the new code.
- Outputs are registered; no combinational path from any input to any output.

## Test plan
- Reset, CNT_MAX=9, DEB_MAX=4, dir=1: code 000 after reset, steps every 10 clocks through 001..110, then 000; 3'b111 never observed; step_pulse one cycle per step.
- AUTO, dir=0 from reset: first step gives 110, then 101; dir toggled to 1 mid-run: next step goes up from current code.
- key_mode held low 20 clocks: exactly one toggle, auto_mode 1->0, code frozen; key_step pressed 3 times in MANUAL with dir=1: code advances 3, one step_pulse each.
- key_step bouncing (low 2 clocks, high 1, low 3) then stable low 10 clocks: exactly one step; key_step presses in AUTO: no extra steps.
- mode press landing on the auto tick cycle: auto_mode toggles, code unchanged, step_pulse stays 0.
- sys_rst_n pulsed low while code = 101 in MANUAL: immediately code 000, auto_mode 1, step_pulse 0; next step 10 clocks after release.
